game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000, clk cycles per movement tick.
REQ-002 SHALL have parameter HIT_TOP, default 400, first obj_y row inside the hit window.
REQ-003 SHALL have parameter HIT_BOT, default 475, last obj_y row inside the hit window.
REQ-004 SHALL have parameter Y_WRAP, default 779, largest legal obj_y.
REQ-005 SHALL have parameter START_Y, default 320, parked obj_y in IDLE.
REQ-006 SHALL have parameter LIVES_INIT, default 3, lives at game start.
REQ-007 SHALL have parameter SPEEDUP_EVERY, default 8, hits per speed level.
REQ-008 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-009 SHALL have port reset, input, 1, synchronous, active-high.
REQ-010 SHALL have port button, input, 1, player button, already synchronous to clk.
REQ-011 SHALL have port obj_y, output, 10, falling object top row.
REQ-012 SHALL have port score, output, 16, hit count.
REQ-013 SHALL have port lives, output, 2, remaining lives.
REQ-014 SHALL have port level, output, 2, speed level 0..3.
REQ-015 SHALL have port state, output, 2, FSM state code.
REQ-016 SHALL have port hit_pulse, output, 1, one-cycle strobe on a scored hit.
REQ-017 SHALL have port miss_pulse, output, 1, one-cycle strobe on a missed pass.

Function
REQ-018 SHALL define press as a button rising edge, meaning button=1 this cycle and 0 the previous cycle.
REQ-019 SHALL have FSM states IDLE=0, PLAY=1, OVER=2 and PAUSE=3 (PAUSE only per REQ-032).
REQ-020 In IDLE, SHALL hold obj_y=START_Y and freeze the tick counter; a press SHALL clear score, load lives=LIVES_INIT, set level=0, set armed=1 and go to PLAY.
REQ-021 In PLAY, the tick counter SHALL count 0..TICK_DIV-1; at TICK_DIV-1 it SHALL wrap to 0 and issue one move tick.
REQ-022 On a move tick, obj_y SHALL advance by step=1+level; if obj_y+step exceeds Y_WRAP, obj_y SHALL become 0 and armed SHALL be set to 1.
REQ-023 A press in PLAY with armed=1 and HIT_TOP<=obj_y<=HIT_BOT SHALL increment score (saturating at 16'hFFFF), pulse hit_pulse and clear armed; presses outside the window, or with armed=0, SHALL be ignored.
REQ-024 On a move tick where obj_y<=HIT_BOT and the new obj_y>HIT_BOT with armed=1, the block SHALL pulse miss_pulse, decrement lives and clear armed.
REQ-025 On every SPEEDUP_EVERY-th hit, level SHALL increment, saturating at 3.
REQ-026 When a hit and a move tick fall on the same cycle, the window test SHALL use the pre-move obj_y, the hit SHALL win, and no miss SHALL be raised.
REQ-027 When lives reaches 0 via a miss, the FSM SHALL enter OVER on the next cycle; in OVER, obj_y, score and level SHALL hold, and a press SHALL return to IDLE.
REQ-028 hit_pulse and miss_pulse SHALL be registered and never both high in the same cycle.

Reset
REQ-029 reset SHALL force state=IDLE, obj_y=START_Y, score=0, lives=LIVES_INIT, level=0, tick counter=0, armed=1, both pulses=0 and the edge-detect register=0, in any state and on the cycle after assertion.
REQ-030 A button held high across reset release SHALL NOT generate a press.

Configuration
REQ-031 Without GAME_SEQ_PAUSE_EN, port pause_btn SHALL be absent and PAUSE unreachable.
REQ-032 With GAME_SEQ_PAUSE_EN, port pause_btn (input, 1) SHALL be present; its rising edge SHALL toggle PLAY<->PAUSE, and PAUSE SHALL freeze the tick counter, obj_y and armed, and ignore button.

Structure
REQ-033 Package game_pkg SHALL hold the state encodings, the default geometry constants (START_Y, HIT_TOP, HIT_BOT, Y_WRAP) and the level width.
REQ-034 Rising-edge detection SHALL be the sub-module edge_detect, instantiated once per button input.

Verification
REQ-035 With TICK_DIV=4: reset then a press -> state=PLAY, score=0, lives=3; after 4 cycles obj_y=321.
REQ-036 With obj_y=410 and armed=1, a press -> score+1, hit_pulse high 1 cycle; a second press at obj_y=420 -> score unchanged.
REQ-037 Object crosses 475->476 with no press -> miss_pulse once, lives 3->2; after 3 misses -> state=OVER, then a press -> IDLE, obj_y=320.
REQ-038 With level=2 and obj_y=778, a move tick -> obj_y=0 and armed=1; after 8 hits level=1, and it stays 3 after 32+ hits.
REQ-039 A press and a move tick on the same cycle with obj_y=475 -> hit counted and no miss; reset asserted mid-PLAY -> all reset values next cycle.
REQ-040 With GAME_SEQ_PAUSE_EN: a pause_btn edge in PLAY -> obj_y frozen for 100 cycles; a second edge -> motion resumes.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the falling-object game sequencer.
//   - game_state_t : FSM state encodings (also driven out on the state port)
//   - GAME_*       : default playfield geometry used as parameter defaults
//   - field widths : object row, score, lives, speed level
//   - sat_inc      : saturating increment for the score counter
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_OVER  = 2'd2,
      ST_PAUSE = 2'd3
   } game_state_t;

   localparam int unsigned GAME_START_Y = 320;
   localparam int unsigned GAME_HIT_TOP = 400;
   localparam int unsigned GAME_HIT_BOT = 475;
   localparam int unsigned GAME_Y_WRAP  = 779;

   localparam int unsigned Y_W     = 10;
   localparam int unsigned SCORE_W = 16;
   localparam int unsigned LIVES_W = 2;
   localparam int unsigned LEVEL_W = 2;

   localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (v == '1) ? v : v + SCORE_W'(1);
   endfunction

endpackage

// File: rtl/game_sequencer_edge_detect.sv
// Rising-edge detector for a button that is already synchronous to clk.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   din   - button level
//   rise  - high for the cycle in which din is 1 and was 0 on the previous cycle
// A button that is held high while reset is released is not a new press:
// the level seen during reset blocks detection until the button is seen low.
module edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic prev_q;
   logic blocked_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q    <= 1'b0;
         blocked_q <= din;
      end else begin
         prev_q <= din;
         if (!din) begin
            blocked_q <= 1'b0;
         end
      end
   end

   assign rise = din & ~prev_q & ~blocked_q;

endmodule

// File: rtl/game_sequencer.sv
// Falling-object reaction game sequencer.
// An object falls down the playfield one move tick at a time; the player scores
// by pressing while the object is inside the hit window, and loses a life when
// an armed object leaves the window unpressed. Every SPEEDUP_EVERY hits the
// speed level (and so the step per tick) goes up, saturating at 3.
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous active-high reset
//   button     - player button (synchronous to clk)
//   pause_btn  - pause toggle button, only present with GAME_SEQ_PAUSE_EN
//   obj_y      - falling object top row
//   score      - hit count, saturating
//   lives      - remaining lives
//   level      - speed level 0..3
//   state      - FSM state code
//   hit_pulse  - one-cycle strobe on a scored hit
//   miss_pulse - one-cycle strobe on a missed pass
// Build option: define GAME_SEQ_PAUSE_EN to add pause_btn and the PAUSE state.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | object parked at START_Y, waiting for a press to start a game
// ST_PLAY  | object moving, presses and misses scored
// ST_OVER  | no lives left; display held until a press returns to idle
// ST_PAUSE | motion and scoring frozen (GAME_SEQ_PAUSE_EN builds only)
module game_sequencer
   import game_pkg::*;
#(
   parameter int unsigned TICK_DIV      = 500000,
   parameter int unsigned HIT_TOP       = GAME_HIT_TOP,
   parameter int unsigned HIT_BOT       = GAME_HIT_BOT,
   parameter int unsigned Y_WRAP        = GAME_Y_WRAP,
   parameter int unsigned START_Y       = GAME_START_Y,
   parameter int unsigned LIVES_INIT    = 3,
   parameter int unsigned SPEEDUP_EVERY = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               button,
`ifdef GAME_SEQ_PAUSE_EN
   input  logic               pause_btn,
`endif
   output logic [Y_W-1:0]     obj_y,
   output logic [SCORE_W-1:0] score,
   output logic [LIVES_W-1:0] lives,
   output logic [LEVEL_W-1:0] level,
   output logic [1:0]         state,
   output logic               hit_pulse,
   output logic               miss_pulse
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned HC_W  = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;
   // Row arithmetic is done one bit wider so obj_y + step cannot overflow.
   localparam int unsigned YX_W  = Y_W + 1;

   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TICK_DIV - 1);
   localparam logic [HC_W-1:0]    HC_LAST   = HC_W'(SPEEDUP_EVERY - 1);
   localparam logic [Y_W-1:0]     START_Y_V = Y_W'(START_Y);
   localparam logic [YX_W-1:0]    HIT_TOP_V = YX_W'(HIT_TOP);
   localparam logic [YX_W-1:0]    HIT_BOT_V = YX_W'(HIT_BOT);
   localparam logic [YX_W-1:0]    Y_WRAP_V  = YX_W'(Y_WRAP);
   localparam logic [LIVES_W-1:0] LIVES_V   = LIVES_W'(LIVES_INIT);

   game_state_t        state_q, state_d;
   logic [Y_W-1:0]     obj_y_q, obj_y_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [HC_W-1:0]    hit_cnt_q, hit_cnt_d;
   logic               armed_q, armed_d;
   logic               hit_q, hit_d;
   logic               miss_q, miss_d;

   logic               press;
   logic               tick;
   logic               in_window;
   logic [2:0]         step;
   logic [YX_W-1:0]    y_cur;
   logic [YX_W-1:0]    y_sum;

   edge_detect u_btn_edge (
      .clk   (clk),
      .reset (reset),
      .din   (button),
      .rise  (press)
   );

`ifdef GAME_SEQ_PAUSE_EN
   logic pause_press;

   edge_detect u_pause_edge (
      .clk   (clk),
      .reset (reset),
      .din   (pause_btn),
      .rise  (pause_press)
   );
`endif

   // Window test and move arithmetic always use the pre-move row, so a press
   // landing on the same cycle as a tick is judged where the player saw it.
   assign step      = 3'(level_q) + 3'd1;
   assign y_cur     = {1'b0, obj_y_q};
   assign y_sum     = y_cur + YX_W'(step);
   assign in_window = (y_cur >= HIT_TOP_V) && (y_cur <= HIT_BOT_V);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         obj_y_q    <= START_Y_V;
         score_q    <= '0;
         lives_q    <= LIVES_V;
         level_q    <= '0;
         tick_cnt_q <= '0;
         hit_cnt_q  <= '0;
         armed_q    <= 1'b1;
         hit_q      <= 1'b0;
         miss_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         obj_y_q    <= obj_y_d;
         score_q    <= score_d;
         lives_q    <= lives_d;
         level_q    <= level_d;
         tick_cnt_q <= tick_cnt_d;
         hit_cnt_q  <= hit_cnt_d;
         armed_q    <= armed_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      obj_y_d    = obj_y_q;
      score_d    = score_q;
      lives_d    = lives_q;
      level_d    = level_q;
      tick_cnt_d = tick_cnt_q;
      hit_cnt_d  = hit_cnt_q;
      armed_d    = armed_q;
      hit_d      = 1'b0;
      miss_d     = 1'b0;
      tick       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            obj_y_d = START_Y_V;
            if (press) begin
               score_d    = '0;
               lives_d    = LIVES_V;
               level_d    = '0;
               armed_d    = 1'b1;
               hit_cnt_d  = '0;
               tick_cnt_d = '0;
               state_d    = ST_PLAY;
            end
         end

         ST_PLAY: begin
            tick       = (tick_cnt_q == CNT_LAST);
            tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);

            hit_d = press && armed_q && in_window;
            if (hit_d) begin
               score_d = sat_inc(score_q);
               armed_d = 1'b0;
               if (hit_cnt_q == HC_LAST) begin
                  hit_cnt_d = '0;
                  if (level_q != LEVEL_MAX) begin
                     level_d = level_q + LEVEL_W'(1);
                  end
               end else begin
                  hit_cnt_d = hit_cnt_q + HC_W'(1);
               end
            end

            if (tick) begin
               if (y_sum > Y_WRAP_V) begin
                  obj_y_d = '0;
                  armed_d = 1'b1;
               end else begin
                  obj_y_d = y_sum[Y_W-1:0];
                  // A same-cycle hit has already disarmed the object, so it
                  // can never also count as a miss.
                  if (!hit_d && armed_q && (y_cur <= HIT_BOT_V) && (y_sum > HIT_BOT_V)) begin
                     miss_d  = 1'b1;
                     armed_d = 1'b0;
                     lives_d = lives_q - LIVES_W'(1);
                     if (lives_d == '0) begin
                        state_d = ST_OVER;
                     end
                  end
               end
            end

`ifdef GAME_SEQ_PAUSE_EN
            // Game over takes precedence over a pause request on the same cycle.
            if (pause_press && (state_d == ST_PLAY)) begin
               state_d = ST_PAUSE;
            end
`endif
         end

         ST_OVER: begin
            if (press) begin
               obj_y_d = START_Y_V;
               state_d = ST_IDLE;
            end
         end

         ST_PAUSE: begin
`ifdef GAME_SEQ_PAUSE_EN
            if (pause_press) begin
               state_d = ST_PLAY;
            end
`else
            state_d = ST_IDLE;
`endif
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign obj_y      = obj_y_q;
   assign score      = score_q;
   assign lives      = lives_q;
   assign level      = level_q;
   assign state      = state_q;
   assign hit_pulse  = hit_q;
   assign miss_pulse = miss_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Testbench for game_sequencer (TICK_DIV=4, default geometry).
// Randomized play against a behavioural game model; hit/miss events are queued
// by the model and checked by an independent monitor when the DUT strobes.
// Define GAME_SEQ_PAUSE_EN to also exercise the pause toggle.
`timescale 1ns/1ps
module tb_game_sequencer;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        button = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
   logic        pause_btn = 1'b0;
`endif
   logic [9:0]  obj_y;
   logic [15:0] score;
   logic [1:0]  lives;
   logic [1:0]  level;
   logic [1:0]  state;
   logic        hit_pulse;
   logic        miss_pulse;

   game_sequencer #(.TICK_DIV(TD)) dut (
      .clk        (clk),
      .reset      (reset),
      .button     (button),
`ifdef GAME_SEQ_PAUSE_EN
      .pause_btn  (pause_btn),
`endif
      .obj_y      (obj_y),
      .score      (score),
      .lives      (lives),
      .level      (level),
      .state      (state),
      .hit_pulse  (hit_pulse),
      .miss_pulse (miss_pulse)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit is_hit;
      int score;
      int lives;
      int level;
   } ev_t;
   ev_t exp_q[$];

   // Game model: plain rules on integers.
   int m_state = 0;
   int m_y = 320;
   int m_score = 0;
   int m_lives = 3;
   int m_level = 0;
   int m_armed = 1;
   int m_cnt = 0;
   int m_hits = 0;
   bit m_prev = 0;
   bit m_pprev = 0;
   bit ev_pushed = 0;

   task automatic check(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
      end
   endtask

   task automatic model_step(input bit b, input bit r, input bit pb);
      bit press, ppress, tick, hit;
      int ny;
      ev_pushed = 0;
      press  = b && !m_prev;
      ppress = pb && !m_pprev;
      m_prev  = b;
      m_pprev = pb;
      if (r) begin
         m_state = 0; m_y = 320; m_score = 0; m_lives = 3; m_level = 0;
         m_cnt = 0; m_armed = 1; m_hits = 0;
         return;
      end
      case (m_state)
         0: begin
            m_y = 320;
            if (press) begin
               m_score = 0; m_lives = 3; m_level = 0; m_armed = 1;
               m_hits = 0; m_cnt = 0; m_state = 1;
            end
         end
         1: begin
            tick = (m_cnt == TD - 1);
            m_cnt = tick ? 0 : m_cnt + 1;
            ny = m_y + 1 + m_level;
            hit = press && (m_armed != 0) && m_y >= 400 && m_y <= 475;
            if (hit) begin
               if (m_score < 65535) m_score++;
               m_armed = 0;
               m_hits++;
               if (m_hits % 8 == 0 && m_level < 3) m_level++;
               exp_q.push_back('{1'b1, m_score, m_lives, m_level});
               ev_pushed = 1;
            end
            if (tick) begin
               if (ny > 779) begin
                  m_y = 0;
                  m_armed = 1;
               end else begin
                  if (!hit && m_armed != 0 && m_y <= 475 && ny > 475) begin
                     m_lives--;
                     m_armed = 0;
                     exp_q.push_back('{1'b0, m_score, m_lives, m_level});
                     ev_pushed = 1;
                     if (m_lives == 0) m_state = 2;
                  end
                  m_y = ny;
               end
            end
            if (ppress && m_state == 1) m_state = 3;
         end
         2: begin
            if (press) begin
               m_state = 0;
               m_y = 320;
            end
         end
         default: begin
            if (ppress) m_state = 1;
         end
      endcase
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic cycle(input bit b, input bit r, input bit pb);
      logic [31:0] act, expv;
      button = b;
      reset  = r;
`ifdef GAME_SEQ_PAUSE_EN
      pause_btn = pb;
`endif
      model_step(b, r, pb);
      @(posedge clk);
      #2;
      act  = {state, obj_y, score, lives, level};
      expv = {2'(m_state), 10'(m_y), 16'(m_score), 2'(m_lives), 2'(m_level)};
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL snapshot at %0t: got state=%0d y=%0d score=%0d lives=%0d level=%0d, expected state=%0d y=%0d score=%0d lives=%0d level=%0d",
                  $time, state, obj_y, score, lives, level, m_state, m_y, m_score, m_lives, m_level);
      end
      if (ev_pushed) begin
         check("event_presented", exp_q.size(), 0);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   // Monitor: pops one expected event per DUT strobe.
   initial begin
      ev_t e;
      forever begin
         @(posedge clk);
         #1;
         if (hit_pulse || miss_pulse) begin
            check("pulse_exclusive", int'(hit_pulse & miss_pulse), 0);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_pulse at %0t: hit=%0d miss=%0d, expected no strobe",
                        $time, hit_pulse, miss_pulse);
            end else begin
               e = exp_q.pop_front();
               check("ev_kind_hit", int'(hit_pulse), int'(e.is_hit));
               check("ev_score", int'(score), e.score);
               check("ev_lives", int'(lives), e.lives);
               check("ev_level", int'(level), e.level);
            end
         end
      end
   end

   task automatic run_until_y(input int y, input int budget);
      int n;
      n = 0;
      while (m_y != y && n < budget) begin
         cycle(0, 0, 0);
         n++;
      end
      if (m_y != y) begin
         tests++;
         fails++;
         $display("FAIL wait_for_row_%0d: budget expired, dut y=%0d", y, obj_y);
      end
   endtask

   initial begin
      int n;
      int target;
      bit want, b, last_b, chk8;

      @(negedge clk);
      repeat (3) cycle(0, 1, 0);
      check("rst_state", int'(state), 0);
      check("rst_obj_y", int'(obj_y), 320);
      check("rst_score", int'(score), 0);
      check("rst_lives", int'(lives), 3);
      check("rst_level", int'(level), 0);
      check("rst_pulses", int'({hit_pulse, miss_pulse}), 0);

      // Button held high through reset release must not start a game.
      cycle(1, 1, 0);
      repeat (4) cycle(1, 0, 0);
      check("held_btn_no_press", int'(state), 0);
      cycle(0, 0, 0);

      cycle(1, 0, 0);
      check("start_state", int'(state), 1);
      check("start_score", int'(score), 0);
      check("start_lives", int'(lives), 3);
      repeat (4) cycle(0, 0, 0);
      check("first_move_y", int'(obj_y), 321);

      // Hit at 410, ignored second press at 420, then run out of lives.
      run_until_y(410, 1000);
      cycle(1, 0, 0);
      check("hit410_score", int'(score), 1);
      check("hit410_pulse", int'(hit_pulse), 1);
      cycle(0, 0, 0);
      check("hit410_pulse_low", int'(hit_pulse), 0);
      run_until_y(420, 200);
      cycle(1, 0, 0);
      check("press420_ignored", int'(score), 1);
      n = 0;
      while (m_state != 2 && n < 20000) begin
         cycle(0, 0, 0);
         n++;
      end
      check("over_state", int'(state), 2);
      check("over_lives", int'(lives), 0);
      repeat (8) cycle(0, 0, 0);
      check("over_hold_score", int'(score), 1);
      cycle(1, 0, 0);
      check("over_to_idle", int'(state), 0);
      check("idle_obj_y", int'(obj_y), 320);
      cycle(0, 0, 0);

      // Skilled play with random extra presses, up to level saturation.
      cycle(1, 0, 0);
      last_b = 1;
      chk8 = 0;
      target = 999;
      n = 0;
      while (n < 70000 && m_hits < 34 && m_state == 1) begin
         want = 0;
         if (m_armed != 0 && m_y >= 400 && m_y <= 475) begin
            if (m_y >= target) want = 1;
            else if (m_y + 1 + m_level > 475 && m_cnt == TD - 1) want = 1;
         end
         if ($urandom_range(299, 0) == 0) want = 1;
         b = want && !last_b;
         if (b && m_armed != 0 && m_y >= 400 && m_y <= 475)
            target = ($urandom_range(2, 0) == 0) ? 999 : int'($urandom_range(475, 400));
         cycle(b, 0, 0);
         last_b = b;
         if (m_hits == 8 && !chk8) begin
            check("level_after_8_hits", int'(level), 1);
            chk8 = 1;
         end
         n++;
      end
      if (m_hits < 34) begin
         tests++;
         fails++;
         $display("FAIL play_budget: only %0d hits reached, dut score=%0d", m_hits, score);
      end
      check("level_saturated", int'(level), 3);
      check("score_after_play", int'(score), m_hits);
      repeat (50) cycle(0, 0, 0);

`ifdef GAME_SEQ_PAUSE_EN
      begin
         int y0;
         cycle(0, 0, 1);
         check("pause_state", int'(state), 3);
         y0 = obj_y;
         repeat (100) cycle(1, 0, 0);
         check("pause_frozen", int'(obj_y), y0);
         cycle(0, 0, 1);
         repeat (2 * TD) cycle(0, 0, 0);
         check("pause_resumed", int'(obj_y != 10'(y0)), 1);
      end
`endif

      // Reset in the middle of a game.
      cycle(0, 1, 0);
      check("midrst_state", int'(state), 0);
      check("midrst_obj_y", int'(obj_y), 320);
      check("midrst_score", int'(score), 0);
      check("midrst_lives", int'(lives), 3);
      check("midrst_level", int'(level), 0);
      cycle(0, 0, 0);
      check("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
